// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch stage with pipelined Wishbone reads and a prefetch queue.
// Redirects flush the queue and drop responses to requests issued before the redirect.
module fetch_prefetch #(
  parameter int          DEPTH             = 4,
  parameter int          MAX_OUTSTANDING   = 2,
  parameter logic [31:0] BOOT_ADDRESS      = 32'h0000_0000,
  parameter logic [31:0] INTERRUPT_ADDRESS = 32'h0000_0010,
  parameter logic [31:0] DEBUG_ADDRESS     = 32'h0000_0020
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_i,
  input  logic        drq_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  localparam int QW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [31:0]   pc_q, pc_d, adr_q, adr_d, ack_pc_q, ack_pc_d, target, fetch_pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pcs_q [DEPTH];
  logic [OW-1:0] out_q, out_d, disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] rd_q, wr_q;
  logic          stb_q, stb_d, stale_q, stale_d;
  logic          redirect, accept, ack_v, push, pop, issue;
  assign wb_we_o        = 1'b0;
  assign wb_sel_o       = 4'hF;
  assign wb_stb_o       = stb_q;
  assign wb_adr_o       = adr_q;
  assign wb_cyc_o       = stb_q | (out_q != '0);
  assign output_valid_o = cnt_q != '0;
  assign instr_o        = output_valid_o ? instr_q[rd_q] : '0;
  assign pc_o           = output_valid_o ? pcs_q[rd_q] : '0;
  always_comb begin
    redirect = drq_i | irq_i | branch_i;
    target   = drq_i ? DEBUG_ADDRESS : irq_i ? INTERRUPT_ADDRESS : branch_target_i;
    accept   = stb_q & ~wb_stall_i;
    ack_v    = wb_ack_i & (out_q != '0);
    push     = ack_v & ~redirect & (disc_q == '0);
    pop      = output_valid_o & output_ready_i;
    out_d    = out_q + OW'(accept) - OW'(ack_v);
    cnt_d    = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    // a request stalled across a redirect is still accepted later and its response dropped
    disc_d   = redirect ? out_d : disc_q - OW'(ack_v && disc_q != '0) + OW'(accept & stale_q);
    stale_d  = stb_q & ~accept & (stale_q | redirect);
    fetch_pc = redirect ? target : pc_q;
    issue    = (~stb_q | accept) && (32'(out_d) < MAX_OUTSTANDING) && (32'(cnt_d) + 32'(out_d) < DEPTH);
    stb_d    = issue | (stb_q & ~accept);
    adr_d    = issue ? fetch_pc : adr_q;
    pc_d     = issue ? fetch_pc + 32'd4 : fetch_pc;
    // kept responses are contiguous from the last redirect target
    ack_pc_d = redirect ? target : push ? ack_pc_q + 32'd4 : ack_pc_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= BOOT_ADDRESS;
      ack_pc_q <= BOOT_ADDRESS;
      adr_q    <= '0;
      stb_q    <= 1'b0;
      stale_q  <= 1'b0;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      ack_pc_q <= ack_pc_d;
      adr_q    <= adr_d;
      stb_q    <= stb_d;
      stale_q  <= stale_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      rd_q     <= redirect ? '0 : rd_q + QW'(pop);
      wr_q     <= redirect ? '0 : wr_q + QW'(push);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_q] <= wb_dat_i;
      pcs_q[wr_q]   <= ack_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: cycle vectors, directed redirect/wrap/reset sequences and a randomized
// run checked against an in-order instruction stream model with an in-bench Wishbone memory.
module tb_fetch_prefetch;
  localparam int          MAXO = 2;
  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] IRQA = 32'h0000_0010;
  localparam logic [31:0] DBGA = 32'h0000_0020;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        irq = 1'b0, drq = 1'b0, branch = 1'b0;
  logic [31:0] br_tgt = '0, wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0, ready = 1'b0;
  logic [31:0] wb_adr_o, instr_o, pc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, output_valid_o;
  typedef struct { logic [31:0] a; int due; } req_t;
  typedef struct { bit rst, stall, rdy, e_stb, e_cyc, e_valid; logic [31:0] e_adr, e_pc; } vec_t;
  req_t        pend[$];
  vec_t        vecs[$];
  int          errors = 0, checks = 0, cyc = 0, lat = 1, hs_cnt = 0;
  bit          rand_lat = 0, prev_stall = 0, prev_redir = 0;
  logic [31:0] prev_adr = '0, exp_pc = BOOT, key = '0;

  fetch_prefetch #(.DEPTH(4), .MAX_OUTSTANDING(MAXO), .BOOT_ADDRESS(BOOT),
                   .INTERRUPT_ADDRESS(IRQA), .DEBUG_ADDRESS(DBGA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .drq_i(drq), .branch_i(branch),
    .branch_target_i(br_tgt), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i), .output_ready_i(ready), .output_valid_o(output_valid_o),
    .instr_o(instr_o), .pc_o(pc_o));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {irq, drq, branch, wb_ack_i, wb_stall_i, ready} = '0;
    pend.delete();
    exp_pc = BOOT;
    prev_stall = 0;
    prev_redir = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Called at a falling edge with stall/ready/redirect inputs already chosen for this cycle.
  task automatic tick();
    chk("cyc_rule", wb_cyc_o, wb_stb_o || pend.size() != 0);
    chk("outstanding_max", pend.size() <= MAXO, 1);
    if (prev_stall) begin
      chk("stall_stb_held", wb_stb_o, 1);
      chk("stall_adr_held", wb_adr_o, prev_adr);
    end
    if (prev_redir) chk("flush_valid", output_valid_o, 0);
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      wb_ack_i = 1'b1;
      wb_dat_i = pend[0].a ^ key;
      void'(pend.pop_front());
    end else begin
      wb_ack_i = 1'b0;
      wb_dat_i = $urandom;
    end
    if (wb_stb_o && !wb_stall_i)
      pend.push_back('{wb_adr_o, cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat)});
    prev_stall = wb_stb_o && wb_stall_i;
    prev_adr = wb_adr_o;
    if (output_valid_o && ready) begin
      chk("stream_pc", pc_o, exp_pc);
      chk("stream_instr", instr_o, exp_pc ^ key);
      exp_pc += 32'd4;
      hs_cnt++;
    end
    prev_redir = drq || irq || branch;
    if (drq) exp_pc = DBGA;
    else if (irq) exp_pc = IRQA;
    else if (branch) exp_pc = br_tgt;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_hs(input string nm, input logic [31:0] exp);
    int n = 0;
    while (!(output_valid_o && ready) && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) begin
      checks++;
      errors++;
      $display("FAIL %s: no handshake within 40 cycles, required pc %h", nm, exp);
    end else begin
      chk(nm, pc_o, exp);
      chk({nm, "_instr"}, instr_o, exp ^ key);
      tick();
    end
  endtask

  function automatic vec_t v(bit r, bit s, bit rd, bit st, logic [31:0] a, bit cy, bit vl, logic [31:0] p);
    vec_t x;
    x.rst = r; x.stall = s; x.rdy = rd; x.e_stb = st; x.e_adr = a; x.e_cyc = cy; x.e_valid = vl; x.e_pc = p;
    return x;
  endfunction

  initial begin
    // zero-wait startup: pc 0,4,8,12 from two cycles after the first strobe
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 8, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 12, 1, 1, 4));
    vecs.push_back(v(0, 0, 1, 1, 16, 1, 1, 8));
    vecs.push_back(v(0, 0, 1, 1, 20, 1, 1, 12));
    // decode not ready: four requests fill the queue, then drain and resume at 16
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 8, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 12, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 16, 1, 1, 4));
    vecs.push_back(v(0, 0, 1, 1, 20, 1, 1, 8));
    vecs.push_back(v(0, 0, 1, 1, 24, 1, 1, 12));
    vecs.push_back(v(0, 0, 1, 1, 28, 1, 1, 16));
    // first request stalled three cycles: first output three cycles late
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 4, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 8, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 12, 1, 1, 4));

    do_reset();
    chk("reset_stb", wb_stb_o, 0);
    chk("reset_cyc", wb_cyc_o, 0);
    chk("reset_valid", output_valid_o, 0);
    chk("reset_adr", wb_adr_o, 0);
    chk("reset_we_sel", {wb_we_o, wb_sel_o}, 5'h0F);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      chk($sformatf("vec%0d_stb", i), wb_stb_o, vecs[i].e_stb);
      chk($sformatf("vec%0d_cyc", i), wb_cyc_o, vecs[i].e_cyc);
      chk($sformatf("vec%0d_valid", i), output_valid_o, vecs[i].e_valid);
      if (vecs[i].e_stb) chk($sformatf("vec%0d_adr", i), wb_adr_o, vecs[i].e_adr);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].e_pc);
      end
      wb_stall_i = vecs[i].stall;
      ready = vecs[i].rdy;
      tick();
    end

    // branch with two requests in flight at latency 3: both responses dropped
    do_reset();
    lat = 3;
    ready = 1'b1;
    repeat (3) tick();
    chk("br_credit_stb", wb_stb_o, 0);
    branch = 1'b1;
    br_tgt = 32'h0000_0100;
    tick();
    branch = 1'b0;
    chk("br_flush_valid", output_valid_o, 0);
    wait_hs("br_first", 32'h0000_0100);
    wait_hs("br_second", 32'h0000_0104);

    // simultaneous redirects: debug wins
    lat = 1;
    repeat (5) tick();
    {drq, irq, branch} = 3'b111;
    br_tgt = 32'h0000_0300;
    tick();
    {drq, irq, branch} = 3'b000;
    chk("prio_flush_valid", output_valid_o, 0);
    wait_hs("prio_first", DBGA);
    wait_hs("prio_second", DBGA + 32'd4);

    // fetch PC wraps from the top of the address space
    branch = 1'b1;
    br_tgt = 32'hFFFF_FFFC;
    tick();
    branch = 1'b0;
    wait_hs("wrap_top", 32'hFFFF_FFFC);
    wait_hs("wrap_zero", 32'h0000_0000);

    // asynchronous reset mid-burst, then a stray ack after release
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_stb", wb_stb_o, 0);
    chk("areset_cyc", wb_cyc_o, 0);
    chk("areset_valid", output_valid_o, 0);
    chk("areset_adr", wb_adr_o, 0);
    chk("areset_instr", instr_o, 0);
    chk("areset_pc", pc_o, 0);
    do_reset();
    ready = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk);
    cyc++;
    wb_ack_i = 1'b0;
    chk("stray_ack_valid", output_valid_o, 0);
    chk("boot_stb", wb_stb_o, 1);
    chk("boot_adr", wb_adr_o, BOOT);
    wait_hs("stray_first", BOOT);

    // randomized traffic against the stream model
    do_reset();
    key = 32'h1234_5678;
    rand_lat = 1;
    hs_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      wb_stall_i = $urandom_range(0, 3) == 0;
      ready = $urandom_range(0, 9) < 7;
      drq = $urandom_range(0, 79) == 0;
      irq = $urandom_range(0, 59) == 0;
      branch = $urandom_range(0, 24) == 0;
      br_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    chk("rand_progress", hs_cnt >= 100, 1);
    {drq, irq, branch, wb_stall_i} = '0;
    ready = 1'b1;
    rand_lat = 0;
    lat = 1;
    hs_cnt = 0;
    repeat (30) tick();
    chk("drain_rate", hs_cnt >= 20, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction fetch stage with a prefetch queue and pipelined Wishbone reads. It keeps up to `MAX_OUTSTANDING` read requests in flight and buffers up to `DEPTH` fetched instructions with their PCs. It hands them to decode over a valid/ready handshake and flushes everything on debug, interrupt or branch redirects. It replaces the single-request fetch stage between instruction memory and decode, and sustains one instruction per cycle on zero-wait memory.

## Interface
- `DEPTH`, default 4: prefetch queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unacknowledged reads; 1..DEPTH.
- `BOOT_ADDRESS`, default 32'h0000_0000: first fetch PC after reset.
- `INTERRUPT_ADDRESS`, default 32'h0000_0010: irq redirect target.
- `DEBUG_ADDRESS`, default 32'h0000_0020: drq redirect target.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_ni` in 1: reset, asynchronous assertion, active-low.
- `irq_i` in 1: interrupt redirect request.
- `drq_i` in 1: debug redirect request.
- `branch_i` in 1: branch redirect request.
- `branch_target_i` in 32: branch target, sampled when `branch_i` is high.
- `wb_adr_o` out 32: read address.
- `wb_dat_i` in 32: read data.
- `wb_we_o` out 1: constant 0.
- `wb_sel_o` out 4: constant 4'hF.
- `wb_stb_o` out 1: request strobe.
- `wb_ack_i` in 1: response acknowledge.
- `wb_cyc_o` out 1: bus cycle.
- `wb_stall_i` in 1: request not accepted this cycle.
- `output_ready_i` in 1: decode accepts the current instruction.
- `output_valid_o` out 1: `instr_o`/`pc_o` valid.
- `instr_o` out 32: instruction at the queue head.
- `pc_o` out 32: address of `instr_o`.

## Operation
- **Reset.** While `rst_ni` is low, all state is cleared asynchronously:
  - `wb_stb_o`, `wb_cyc_o`, `output_valid_o` = 0
  - `wb_adr_o`, `instr_o`, `pc_o` = 0
  - fetch PC = `BOOT_ADDRESS`; queue empty; outstanding count = 0; discard count = 0
- **Request issue.** A request is issued (`wb_stb_o`=1, `wb_adr_o`=fetch PC) when both hold:
  - outstanding < `MAX_OUTSTANDING`
  - queue count + outstanding < `DEPTH` (credit rule; the queue can never overflow)
- **Acceptance.** A request is accepted when `wb_stb_o`=1 and `wb_stall_i`=0. On acceptance:
  - fetch PC += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0)
  - outstanding += 1
- **Stalled request.** While `wb_stall_i`=1, `wb_stb_o` and `wb_adr_o` are held unchanged.
- **Bus cycle.** `wb_cyc_o` = 1 whenever `wb_stb_o`=1 or outstanding > 0; 0 otherwise.
- **Response.** On `wb_ack_i`=1, outstanding -= 1.
  - If discard count > 0: discard count -= 1 and the data is dropped.
  - Otherwise {`wb_dat_i`, request PC} is pushed to the queue. Request PCs are tracked in a FIFO of depth `MAX_OUTSTANDING`.
- **Output.** The queue head drives `instr_o`/`pc_o`; `output_valid_o` = queue not empty. A handshake (valid && ready) pops the head. Push and pop in the same cycle are allowed.
- **Redirect.** A cycle with any of `drq_i`/`irq_i`/`branch_i` high is a redirect. Target priority: drq > irq > branch (`DEBUG_ADDRESS`, `INTERRUPT_ADDRESS`, `branch_target_i`). On a redirect:
  - the queue is flushed and fetch PC = target
  - discard count = outstanding after this cycle's accept/ack; the ack arriving in the redirect cycle itself is dropped
  - a stalled request that is still presented stays on the bus until accepted, then counts toward discard
  - no new request is issued in the redirect cycle
- **Counter widths.**
  - outstanding and discard counters: `$clog2(MAX_OUTSTANDING+1)` bits
  - queue count: `$clog2(DEPTH+1)` bits

## Timing
- The first `wb_stb_o` is asserted on the first rising edge after `rst_ni` deasserts, with `wb_adr_o` = `BOOT_ADDRESS`.
- Ack in cycle N → `output_valid_o`=1 in cycle N+1 with that data (queue empty, no discard pending).
- With zero-wait memory (ack one cycle after acceptance), `MAX_OUTSTANDING`≥2 and `output_ready_i` held at 1: one instruction per cycle.
- A redirect in cycle N gives:
  - `output_valid_o`=0 in N+1
  - new `wb_stb_o` with the target address in N+1, if credits allow
- A handshake in the redirect cycle completes normally: decode has taken that instruction.
- A redirect held for several cycles: each cycle re-flushes and re-targets. Fetching resumes the cycle after the last redirect cycle.
- Discard count > 0 does not block issue; new responses are queued only after all discards are consumed, because acks return in order.
- `rst_ni` low mid-burst: outputs clear immediately. Acks arriving after reset release with outstanding = 0 are ignored.

## Test plan
- Reset release, zero-wait memory returning data = address, `output_ready_i`=1 → `pc_o`/`instr_o` = 0,4,8,12 on consecutive cycles starting 2 cycles after the first `wb_stb_o`.
- `output_ready_i`=0 with `DEPTH`=4 → exactly 4 requests accepted, `wb_stb_o` drops, `wb_cyc_o` drops after the last ack, queue full. Ready raised → 0,4,8,12 drained back-to-back and fetching resumes at 16.
- `wb_stall_i`=1 for 3 cycles on the first request → `wb_adr_o` held at 0 with `wb_stb_o`=1 throughout; first valid output arrives 3 cycles later than the unstalled case.
- Branch to 32'h100 with 2 requests outstanding (ack latency 3) → both acks discarded, next `pc_o` = 32'h100, then 32'h104.
- `drq_i`, `irq_i` and `branch_i` high in the same cycle → next `pc_o` = `DEBUG_ADDRESS`.
- Fetch PC 32'hFFFF_FFFC accepted → next request address 32'h0000_0000.
